// File: rtl/lsu_bus_bridge.sv
// rtl/lsu_bus_bridge.sv - load/store bridge from the core memory port to a valid/ready bus
// Optional LSU_MISALIGN_TRAP_EN: misaligned requests skip the bus and raise misaligned.
module lsu_bus_bridge #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter logic [31:0] RESET_RDATA    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        bus_fault,
`ifdef LSU_MISALIGN_TRAP_EN
   output logic        misaligned,
`endif
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ready,
   input  logic [31:0] bus_rdata
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

   logic [1:0]  r_state;
   logic        r_bus_req;
   logic        r_bus_we;
   logic [31:0] r_bus_addr;
   logic [3:0]  r_bus_be;
   logic [31:0] r_bus_wdata;
   logic [31:0] r_rdata;
   logic        r_fault;
   logic [7:0]  r_cnt;
   logic [1:0]  r_off;
   logic [2:0]  r_funct3;

   logic        w_req;
   logic        w_is_byte;
   logic        w_is_half;
   logic [1:0]  w_off_al;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;
   logic [7:0]  w_cnt_next;
   logic        w_stall;
   logic        w_trap;

   assign w_req      = mem_read | mem_write;
   assign w_is_byte  = (funct3[1:0] == 2'b00);
   assign w_is_half  = (funct3[1:0] == 2'b01);
   assign w_cnt_next = r_cnt + 8'd1;

   // Lane offset with the low bits forced to the natural alignment of the access size.
   always_comb begin
      w_off_al = 2'b00;
      if (w_is_byte) begin
         w_off_al = addr[1:0];
      end else if (w_is_half) begin
         w_off_al = {addr[1], 1'b0};
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_misalign;
   logic r_misaligned;

   assign w_misalign = w_is_half ? addr[0] : (!w_is_byte && (addr[1:0] != 2'b00));
   assign w_trap     = w_misalign;
   assign misaligned = r_misaligned;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_misaligned <= 1'b0;
      end else begin
         r_misaligned <= (r_state == S_IDLE) && w_req && w_misalign;
      end
   end
`else
   assign w_trap = 1'b0;
`endif

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = wdata;
      if (mem_write) begin
         case (funct3[1:0])
            2'b00: begin
               w_be    = 4'b0001 << w_off_al;
               w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
               w_be    = w_off_al[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{wdata[15:0]}};
            end
            default: begin
               w_be    = 4'b1111;
               w_wdata = wdata;
            end
         endcase
      end
   end

   always_comb begin
      w_byte = bus_rdata[7:0];
      case (r_off)
         2'd0:    w_byte = bus_rdata[7:0];
         2'd1:    w_byte = bus_rdata[15:8];
         2'd2:    w_byte = bus_rdata[23:16];
         default: w_byte = bus_rdata[31:24];
      endcase
      w_half = r_off[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (r_funct3[1:0])
         2'b00:   w_load = r_funct3[2] ? {24'h0, w_byte} : {{24{w_byte[7]}}, w_byte};
         2'b01:   w_load = r_funct3[2] ? {16'h0, w_half} : {{16{w_half[15]}}, w_half};
         default: w_load = bus_rdata;
      endcase
   end

   always_comb begin
      case (r_state)
         S_IDLE:  w_stall = w_req;
         S_BUS:   w_stall = 1'b1;
         default: w_stall = 1'b0;
      endcase
   end

   // Reset forces stall low even while the core still presents a request.
   assign stall     = reset & w_stall;
   assign rdata     = r_rdata;
   assign bus_fault = r_fault;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= 32'h0;
         r_bus_be    <= 4'h0;
         r_bus_wdata <= 32'h0;
         r_rdata     <= RESET_RDATA;
         r_fault     <= 1'b0;
         r_cnt       <= 8'h0;
         r_off       <= 2'b00;
         r_funct3    <= 3'b000;
      end else begin
         r_fault <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  if (w_trap) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state     <= S_BUS;
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= mem_write;
                     r_bus_addr  <= {addr[31:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata;
                     r_off       <= w_off_al;
                     r_funct3    <= funct3;
                     r_cnt       <= 8'h0;
                  end
               end
            end
            S_BUS: begin
               if (bus_ready) begin
                  if (!r_bus_we) begin
                     r_rdata <= w_load;
                  end
                  r_bus_req <= 1'b0;
                  r_state   <= S_DONE;
               end else begin
                  r_cnt <= w_cnt_next;
                  if (w_cnt_next == TIMEOUT_LIMIT) begin
                     if (!r_bus_we) begin
                        r_rdata <= RESET_RDATA;
                     end
                     r_bus_req <= 1'b0;
                     r_fault   <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/lsu_bus_bridge.md
Name: lsu_bus_bridge

Overview:
- Load/store unit between the single-cycle RISC-V core's memory port and a memory bus that uses a valid/ready handshake.
- Takes the core's address, write data, memory-access controls and funct3.
- Issues one bus transaction per access, with byte enables and store-data lane replication, and sign- or zero-extends load data.
- Holds the core with a stall signal until the access completes.

Parameters:
- TIMEOUT_CYCLES, 16, maximum number of BUS-state cycles spent waiting for bus_ready before the access is aborted (legal range 1..255).
- RESET_RDATA, 32'h0000_0000, rdata value after reset and after an aborted load.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  core requests a load this cycle.
- mem_write  input  1  core requests a store this cycle. mem_read and mem_write are never both 1.
- funct3  input  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
- addr  input  32  byte address (the core's ALUResult).
- wdata  input  32  store data, taken from the low bits.
- stall  output  1  core must hold PC and state while this is 1.
- rdata  output  32  formatted load result, held stable until the next load completes.
- bus_fault  output  1  one-cycle pulse: access aborted by timeout.
- bus_req  output  1  bus request valid.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address, {addr[31:2],2'b00}.
- bus_be  output  4  byte enables.
- bus_wdata  output  32  lane-replicated store data.
- bus_ready  input  1  bus accepts/completes the transfer this cycle.
- bus_rdata  input  32  read word, valid when bus_ready=1.

Behaviour:
- Reset (asynchronous, reset=0):
  - state=IDLE.
  - bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0.
  - rdata=RESET_RDATA, bus_fault=0, wait counter=0.
  - stall is combinational and therefore also 0.
  - Reset in the middle of an access drops bus_req immediately. Any in-flight response is ignored.
- States: IDLE, BUS, DONE.
- IDLE:
  - stall = mem_read|mem_write (combinational).
  - On a request, register bus_addr, bus_we, bus_be and bus_wdata from the inputs, clear the counter and go to BUS.
- BUS:
  - bus_req=1 and stall=1.
  - All bus_* outputs are held constant until the transfer ends.
  - If bus_ready=1:
    - For a load, capture the formatted bus_rdata into rdata.
    - Go to DONE.
  - Otherwise, increment the counter. When the counter reaches TIMEOUT_CYCLES:
    - Abort: drop bus_req.
    - For a load, set rdata=RESET_RDATA.
    - Set the fault flag and go to DONE.
- DONE:
  - stall=0 and bus_req=0. The core commits its instruction on this edge.
  - bus_fault=1 in this state only if the access was aborted.
  - Always go to IDLE next. The request still visible in this cycle is not relaunched.
- Latency: with a zero-wait bus, an access takes 3 cycles with stall = 1,1,0. Each bus wait cycle adds one cycle.
- Store formatting, with byte offset o=addr[1:0]:
  - SB: be=4'b0001<<o; wdata replicated into all 4 byte lanes.
  - SH: be=4'b0011<<(o[1]*2); halfword replicated into both halves.
  - SW: be=4'b1111.
- Load formatting: select the byte at lane o, or the halfword at lane o[1], or the full word.
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
- Loads drive bus_be=4'b1111.
- An undefined funct3 (011, 110, 111) is treated as LW/SW.
- Misalignment is defined as: halfword with o[0]=1, or word with o!=0. Without the optional feature it is handled by silent alignment: the low address bits used for lane selection are forced to the aligned value, i.e. o[0]=0 for halfwords and o=0 for words.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- When defined:
  - Adds output port misaligned (1 bit).
  - A misaligned request in IDLE issues no bus transaction and goes straight to DONE. stall=1 for that IDLE cycle.
  - misaligned=1 during that DONE cycle; otherwise 0 (reset 0).
  - rdata is unchanged.
- When undefined:
  - The port is absent.
  - Misaligned accesses are silently aligned as described in Behaviour.

Test Plan:
- Zero-wait LW: addr=0x100, bus_ready=1 every cycle, bus_rdata=0xDEADBEEF → bus_addr=0x100, bus_be=1111, stall 1,1,0, rdata=0xDEADBEEF.
- LB/LBU at addr=0x203 with bus_rdata=0x80FF_7F01 → LB rdata=0xFFFFFF80; LBU rdata=0x00000080.
- SH at addr=0x42, wdata=0x1234ABCD → bus_we=1, bus_addr=0x40, bus_be=1100, bus_wdata=0xABCDABCD.
- Bus wait: bus_ready low for 5 cycles then high → bus_req and all bus_* held constant for 6 cycles, stall high for 7 cycles, then one cycle with stall=0.
- Timeout: TIMEOUT_CYCLES=4, bus_ready held 0, LW → bus_req high for 4 cycles, bus_fault pulses 1 cycle, rdata=0, FSM returns to IDLE.
- Reset asserted in BUS mid-wait → bus_req=0 and stall=0 immediately; after release, a new SW at 0x8 completes normally.
